// File: rtl/paddle_pkg.sv
// Shared constants for the paddle render path: geometry, erase colour and
// the render-sequencer state encoding.
package paddle_pkg;

   localparam int          PADDLE_W     = 40;
   localparam int          PADDLE_H     = 8;
   localparam logic [23:0] BG_COLOUR    = 24'h000000;

   // Upstream guarantees these, so 8-bit coordinate sums never wrap in use.
   localparam int          PADDLE_X_MAX = 120;
   localparam int          PADDLE_Y     = 167;

   localparam logic [2:0]  S_IDLE  = 3'd0;
   localparam logic [2:0]  S_ERASE = 3'd1;
   localparam logic [2:0]  S_ARM   = 3'd2;
   localparam logic [2:0]  S_DRAW  = 3'd3;
   localparam logic [2:0]  S_FLUSH = 3'd4;
   localparam logic [2:0]  S_DONE  = 3'd5;

   function automatic logic [7:0] coord_add(input logic [7:0] base,
                                            input logic [7:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/rect_fill_counter.sv
// Row-major 2-D sweep over a W x H rectangle, x fastest. Held at the origin
// while start_i is high; wraps back to the origin after the last cell.
module rect_fill_counter #(
   parameter int W = 40,
   parameter int H = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic                 en_i,
   output logic [$clog2(W)-1:0] x_o,
   output logic [$clog2(H)-1:0] y_o,
   output logic                 last_o
);

   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_end, y_end;

   assign x_end  = (x_q == XW'(W - 1));
   assign y_end  = (y_q == YW'(H - 1));
   assign last_o = x_end && y_end;
   assign x_o    = x_q;
   assign y_o    = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (start_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/paddle_render_ctrl.sv
// Frame-rate paddle refresh: erase the old rectangle if the paddle moved,
// then re-arm paddleDraw and forward its pixels to the VGA plot port.
module paddle_render_ctrl
   import paddle_pkg::*;
#(
   parameter int          P_W   = PADDLE_W,
   parameter int          P_H   = PADDLE_H,
   parameter logic [23:0] P_BG  = BG_COLOUR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frameTick,
   input  logic [7:0]  paddle_x,
   input  logic [7:0]  paddle_y,
   input  logic [7:0]  pix_x,
   input  logic [7:0]  pix_y,
   input  logic [23:0] pix_colour,
   input  logic        paddleDrawEnd,
   output logic        paddleDrawEnable,
   output logic        drawReset,
   output logic [7:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [23:0] vga_colour,
   output logic        vga_plot,
   output logic        busy,
   output logic        renderDone
);

   localparam int XW = $clog2(P_W);
   localparam int YW = $clog2(P_H);

   logic [2:0]    state_q, state_d;
   logic [7:0]    new_x_q, new_x_d, new_y_q, new_y_d;
   logic [7:0]    old_x_q, old_x_d, old_y_q, old_y_d;
   logic          have_old_q, have_old_d;

   logic          dv_q;
   logic [7:0]    dx_q, dy_q;

   logic [XW-1:0] ex;
   logic [YW-1:0] ey;
   logic          erase_last;
   logic          in_erase, in_pass;

   assign in_erase = (state_q == S_ERASE);
   assign in_pass  = (state_q == S_DRAW) || (state_q == S_FLUSH);

   rect_fill_counter #(.W(P_W), .H(P_H)) u_erase_cnt (
      .clk     (clk),
      .reset   (reset),
      .start_i (!in_erase),
      .en_i    (in_erase),
      .x_o     (ex),
      .y_o     (ey),
      .last_o  (erase_last)
   );

   always_comb begin
      state_d    = state_q;
      new_x_d    = new_x_q;
      new_y_d    = new_y_q;
      old_x_d    = old_x_q;
      old_y_d    = old_y_q;
      have_old_d = have_old_q;
      case (state_q)
         S_IDLE: begin
            if (frameTick) begin
               new_x_d = paddle_x;
               new_y_d = paddle_y;
               if (!have_old_q)
                  state_d = S_ARM;
               else if ((paddle_x != old_x_q) || (paddle_y != old_y_q))
                  state_d = S_ERASE;
            end
         end
         S_ERASE: if (erase_last) state_d = S_ARM;
         S_ARM:   state_d = S_DRAW;
         S_DRAW:  if (paddleDrawEnd) state_d = S_FLUSH;
         S_FLUSH: state_d = S_DONE;
         S_DONE: begin
            old_x_d    = new_x_q;
            old_y_d    = new_y_q;
            have_old_d = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         new_x_q    <= '0;
         new_y_q    <= '0;
         old_x_q    <= '0;
         old_y_q    <= '0;
         have_old_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         new_x_q    <= new_x_d;
         new_y_q    <= new_y_d;
         old_x_q    <= old_x_d;
         old_y_q    <= old_y_d;
         have_old_q <= have_old_d;
      end
   end

   // The ROM colour arrives one cycle after its address, so coordinates and
   // the enable are delayed one cycle to line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         dv_q <= 1'b0;
         dx_q <= '0;
         dy_q <= '0;
      end else begin
         dv_q <= paddleDrawEnable;
         dx_q <= pix_x;
         dy_q <= pix_y;
      end
   end

   assign paddleDrawEnable = !reset && (state_q == S_DRAW) && !paddleDrawEnd;
   assign drawReset        = reset || (state_q == S_ARM);

   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = P_BG;
      vga_plot   = 1'b0;
      if (in_erase) begin
         vga_x    = coord_add(old_x_q, 8'(ex));
         vga_y    = coord_add(old_y_q, 8'(ey));
         vga_plot = !reset;
      end else if (in_pass) begin
         vga_x      = dx_q;
         vga_y      = dy_q;
         vga_colour = pix_colour;
         vga_plot   = !reset && dv_q;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign renderDone = (state_q == S_DONE);

endmodule
